muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, fixed 32-cycle latency
// Define MULDIV_DIV_EN to include the restoring divider; otherwise DIV/REM ops complete at once with result 0.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        wb_enable
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_next;
  logic        load, iterate, finish;
  logic [4:0]  count;
  logic [2:0]  op;
  logic        neg;
  logic [31:0] hi, lo, mc;

  logic        a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [31:0] a_mag, b_mag, lo_init, mc_init;

  logic [31:0] src_hi, src_lo, src_mc, step_hi, step_lo;
  logic [32:0] sum;
`ifdef MULDIV_DIV_EN
  logic        src_div, ge;
  logic [32:0] trial;
  logic [31:0] diff, quo, rem_v;
`endif

  logic [63:0] prod, prod_signed;
  logic [31:0] final_res;

  // Operand magnitudes and result sign, decoded straight from the request inputs
  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed & op_a[31];
    b_neg    = b_signed & op_b[31];
    a_mag    = a_neg ? (~op_a + 32'd1) : op_a;
    b_mag    = b_neg ? (~op_b + 32'd1) : op_b;
    if (!funct3[2])
      neg_in = a_neg ^ b_neg;
    else if (funct3[1])
      neg_in = a_neg;
    else
      neg_in = (a_neg ^ b_neg) & (op_b != 32'd0);
    lo_init  = funct3[2] ? a_mag : b_mag;
    mc_init  = funct3[2] ? b_mag : a_mag;
  end

  // One iteration; the first runs on the sampling edge so CALC needs only 31 cycles
  always_comb begin
    if (state == IDLE) begin
      src_hi = 32'd0;
      src_lo = lo_init;
      src_mc = mc_init;
    end else begin
      src_hi = hi;
      src_lo = lo;
      src_mc = mc;
    end
    sum     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_mc} : 33'd0);
    step_hi = sum[32:1];
    step_lo = {sum[0], src_lo[31:1]};
`ifdef MULDIV_DIV_EN
    src_div = (state == IDLE) ? funct3[2] : op[2];
    trial   = {src_hi, src_lo[31]};
    ge      = (trial >= {1'b0, src_mc});
    diff    = trial[31:0] - src_mc;
    if (src_div) begin
      step_hi = ge ? diff : trial[31:0];
      step_lo = {src_lo[30:0], ge};
    end
`endif
  end

  always_comb begin
    prod        = {step_hi, step_lo};
    prod_signed = neg ? (~prod + 64'd1) : prod;
    final_res   = (op[1:0] == 2'b00) ? prod_signed[31:0] : prod_signed[63:32];
`ifdef MULDIV_DIV_EN
    quo   = neg ? (~step_lo + 32'd1) : step_lo;
    rem_v = neg ? (~step_hi + 32'd1) : step_hi;
    if (op[2])
      final_res = op[1] ? rem_v : quo;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    iterate    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
`ifdef MULDIV_DIV_EN
          state_next = CALC;
`else
          state_next = funct3[2] ? DONE : CALC;
`endif
        end
      end
      CALC: begin
        iterate = 1'b1;
        if (count == 5'd30) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op     <= 3'd0;
      neg    <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      mc     <= 32'd0;
      count  <= 5'd0;
      result <= 32'd0;
      rd_out <= 5'd0;
    end else if (load) begin
      op     <= funct3;
      neg    <= neg_in;
      hi     <= step_hi;
      lo     <= step_lo;
      mc     <= mc_init;
      count  <= 5'd0;
      result <= 32'd0;
      rd_out <= rd_in;
    end else if (iterate) begin
      hi    <= step_hi;
      lo    <= step_lo;
      count <= count + 5'd1;
      if (finish)
        result <= final_res;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
`ifdef MULDIV_DIV_EN
  assign wb_enable = done & (rd_out != 5'd0);
`else
  assign wb_enable = done & (rd_out != 5'd0) & ~op[2];
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit, both MULDIV_DIV_EN builds
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, wb_enable;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .wb_enable(wb_enable)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64, sb64, p;
    logic        [63:0] up;
    logic signed [31:0] sa32, sb32, q;
    logic               ovf;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    sa32 = a;
    sb32 = b;
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model_result = 32'd0;
    case (f)
      3'd0: model_result = a * b;
      3'd1: begin p = sa64 * sb64; model_result = p[63:32]; end
      3'd2: begin p = sa64 * $signed({32'd0, b}); model_result = p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; model_result = up[63:32]; end
      3'd4: begin
        if (b == 0) model_result = 32'hFFFF_FFFF;
        else if (ovf) model_result = 32'h8000_0000;
        else begin q = sa32 / sb32; model_result = q; end
      end
      3'd5: model_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) model_result = a;
        else if (ovf) model_result = 32'd0;
        else begin q = sa32 % sb32; model_result = q; end
      end
      default: model_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    e.res = model_result(f, a, b);
    e.rd  = rd;
    e.wb  = (rd != 5'd0);
    e.lat = 32;
`ifndef MULDIV_DIV_EN
    if (f[2]) begin
      e.res = 32'd0;
      e.wb  = 1'b0;
      e.lat = 1;
    end
`endif
    return e;
  endfunction

  // Presents one request for a single edge, then scrambles the inputs to prove they were latched
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    sb.push_back(make_exp(f, a, b, rd));
    @(posedge clk); #1;
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    funct3 = 3'($urandom);
    rd_in  = 5'($urandom);
  endtask

  // lat = 1 for the cycle right after the sampling edge
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h want 0", result); end
    vectors++; if (rd_out !== 5'd0) begin miscompares++; $display("FAIL reset_rd_out: got %0d want 0", rd_out); end
    vectors++; if (wb_enable !== 1'b0) begin miscompares++; $display("FAIL reset_wb: got %b want 0", wb_enable); end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_start_discard: busy %b want 0", busy); end
  endtask

  task automatic test_ops;
    int   lat;
    exp_t e;
    vecs.push_back('{3'd0, 32'd7,          32'd6,          5'd5});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4});
    vecs.push_back('{3'd0, 32'd123,        32'd456,        5'd0});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,          5'd14});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd7});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd8});
    vecs.push_back('{3'd5, 32'd100,        32'd0,          5'd9});
    vecs.push_back('{3'd7, 32'd100,        32'd0,          5'd10});
    vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12});
    vecs.push_back('{3'd5, 32'd9,          32'd3,          5'd13});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd0,          5'd1});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd0,          5'd2});
    for (int i = 0; i < 24; i++)
      vecs.push_back('{3'($urandom), $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom, 5'($urandom)});
    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd);
      wait_done(lat);
      e = sb.pop_front();
      vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL op%0d_latency: got %0d want %0d", i, lat, e.lat); end
      vectors++; if (result !== e.res) begin miscompares++; $display("FAIL op%0d_result f=%0d a=%h b=%h: got %h want %h", i, vecs[i].f, vecs[i].a, vecs[i].b, result, e.res); end
      vectors++; if (rd_out !== e.rd) begin miscompares++; $display("FAIL op%0d_rd_out: got %0d want %0d", i, rd_out, e.rd); end
      vectors++; if (wb_enable !== e.wb) begin miscompares++; $display("FAIL op%0d_wb: got %b want %b", i, wb_enable, e.wb); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL op%0d_busy_at_done: got %b want 1", i, busy); end
      @(posedge clk); #1;
      vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL op%0d_pulse: done %b busy %b want 0 0", i, done, busy); end
    end
  endtask

  task automatic test_reset_mid_calc;
    int   lat;
    exp_t e;
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd7; op_b = 32'd6; rd_in = 5'd5; start = 1'b1;
    repeat (11) begin
      @(posedge clk); #1;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midcalc_no_done: got %b want 0", done); end
    end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midcalc_busy: got %b want 1", busy); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midcalc_reset_busy: got %b want 0", busy); end
    vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL midcalc_reset_result: got %h want 0", result); end
    vectors++; if (done !== 1'b0 || wb_enable !== 1'b0) begin miscompares++; $display("FAIL midcalc_reset_done: done %b wb %b want 0 0", done, wb_enable); end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midcalc_after: done %b busy %b want 0 0", done, busy); end
    end
    issue(3'd0, 32'd12345, 32'd678, 5'd9);
    wait_done(lat);
    e = sb.pop_front();
    vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL midcalc_next_latency: got %0d want %0d", lat, e.lat); end
    vectors++; if (result !== e.res) begin miscompares++; $display("FAIL midcalc_next_result: got %h want %h", result, e.res); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int   lat;
    exp_t e;
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17);
    wait_done(lat);
    e = sb.pop_front();
    vectors++; if (lat !== e.lat || result !== e.res) begin miscompares++; $display("FAIL b2b_first: lat %0d res %h want %0d %h", lat, result, e.lat, e.res); end
    funct3 = 3'd0; op_a = 32'h0001_0003; op_b = 32'h0000_0101; rd_in = 5'd22; start = 1'b1;
    sb.push_back(make_exp(3'd0, 32'h0001_0003, 32'h0000_0101, 5'd22));
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_gap: busy %b done %b want 0 0", busy, done); end
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: busy %b want 1", busy); end
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    wait_done(lat);
    e = sb.pop_front();
    vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL b2b_latency: got %0d want %0d", lat, e.lat); end
    vectors++; if (result !== e.res || rd_out !== e.rd) begin miscompares++; $display("FAIL b2b_result: res %h rd %0d want %h %0d", result, rd_out, e.res, e.rd); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    test_reset();
    test_ops();
    test_reset_mid_calc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
